// File: rtl/tjrpu_wb_arbiter.sv
// tjrpu_wb_arbiter: two-master / one-slave Wishbone B4 classic arbiter.
// Master 0 is the management SoC slave port, master 1 the tjrpu core data bus.
// The grant is registered round-robin and is held for the owner's whole cyc.
// Optional stall-timeout watchdog: define TJRPU_WB_ARB_TIMEOUT_EN to build it.
module tjrpu_wb_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic            timeout_o,
    output logic [1:0]      grant_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    // Out-of-range timeout values cannot be represented by the 16-bit counter.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("tjrpu_wb_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] arb;
    logic       rr;
    logic       err_q;

    // Round-robin pick among the currently requesting masters.
    always_comb begin
        arb = IDLE;
        if (m0_cyc_i && m1_cyc_i) begin
            arb = rr ? GNT1 : GNT0;
        end else if (m0_cyc_i) begin
            arb = GNT0;
        end else if (m1_cyc_i) begin
            arb = GNT1;
        end
    end

    // Re-arbitrate only when idle or when the owner has dropped cyc.
    always_comb begin
        state_nxt = state;
        case (state)
            GNT0:    if (!m0_cyc_i) state_nxt = arb;
            GNT1:    if (!m1_cyc_i) state_nxt = arb;
            default: state_nxt = arb;
        endcase
    end

    // Grant register and priority pointer; the pointer flips to the other
    // master whenever a grant is released.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == GNT0 && state_nxt != GNT0) begin
                rr <= 1'b1;
            end else if (state == GNT1 && state_nxt != GNT1) begin
                rr <= 1'b0;
            end
        end
    end

`ifdef TJRPU_WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    // Count consecutive unacked strobe cycles of the current owner; on the
    // last allowed cycle raise a one-cycle error and restart the count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_nxt != state || s_ack_i) begin
                to_cnt <= '0;
            end else if (s_stb_o) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt <= '0;
                    err_q  <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign err_q = 1'b0;
`endif

    // Bus steering: the owner's signals pass straight through, everything
    // else reads zero. During an error cycle the strobe is masked and any
    // late slave ack is swallowed.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~err_q;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i & ~err_q;
                m0_err_o = err_q;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~err_q;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i & ~err_q;
                m1_err_o = err_q;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    assign timeout_o = err_q;
    assign grant_o   = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_tjrpu_wb_arbiter.sv
// Testbench for tjrpu_wb_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_tjrpu_wb_arbiter;

    localparam int TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic        timeout_o;
    logic [1:0]  grant_o;

    int checks = 0;
    int failures = 0;

    // model state: owner -1 none / 0 / 1, fav = master preferred on a tie
    int owner, fav, tcnt;
    bit terr;
    logic [70:0] exp_s;
    logic [33:0] exp_m0, exp_m1;
    logic [2:0]  exp_misc;

    tjrpu_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .timeout_o(timeout_o), .grant_o(grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Expected outputs from the model's owner/error state and current inputs.
    task automatic compute_exp();
        bit stb_eff;
        exp_s = '0; exp_m0 = '0; exp_m1 = '0;
        exp_misc = {terr, owner == 1, owner == 0};
        if (owner == 0) begin
            stb_eff = m0_stb_i && !terr;
            exp_s  = {m0_cyc_i, stb_eff, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
            exp_m0 = {s_ack_i && stb_eff, terr, s_dat_i};
        end else if (owner == 1) begin
            stb_eff = m1_stb_i && !terr;
            exp_s  = {m1_cyc_i, stb_eff, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
            exp_m1 = {s_ack_i && stb_eff, terr, s_dat_i};
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        bit [1:0] cyc;
        int nxt;
        bit stalled;
        if (wb_rst_i) begin
            owner = -1; fav = 0; tcnt = 0; terr = 0;
            return;
        end
        cyc = {m1_cyc_i, m0_cyc_i};
        if (owner >= 0 && cyc[owner]) nxt = owner;
        else if (cyc == 2'b11)        nxt = fav;
        else if (cyc[0])              nxt = 0;
        else if (cyc[1])              nxt = 1;
        else                          nxt = -1;
        stalled = exp_s[69] && !s_ack_i;
        if (nxt != owner || s_ack_i) begin
            tcnt = 0; terr = 0;
        end else if (stalled && tcnt == TO - 1) begin
            tcnt = 0; terr = 1;
        end else begin
            if (stalled) tcnt++;
            terr = 0;
        end
`ifndef TJRPU_WB_ARB_TIMEOUT_EN
        terr = 0;
`endif
        if (owner >= 0 && nxt != owner) fav = 1 - owner;
        owner = nxt;
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        compute_exp();
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i} = '0;
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i} = '0;
        s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        clear_inputs();
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== '0) begin
            failures++; $display("FAIL reset_s got=%h exp=0", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o});
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o, timeout_o, grant_o} !== '0) begin
            failures++; $display("FAIL reset_m got=%h exp=0", {m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o, timeout_o, grant_o});
        end
        // m0 served once so the pointer now favours m1
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0000;
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++; $display("FAIL reset_pre_gnt got=%b exp=01", grant_o);
        end
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, grant_o} !== 5'b0) begin
            failures++; $display("FAIL reset_mid got=%b exp=00000", {s_cyc_o, s_stb_o, m0_ack_o, grant_o});
        end
        step();
        wb_rst_i = 1'b0; s_ack_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++; $display("FAIL reset_rr got=%b exp=01", grant_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = 32'h3000_0010;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            failures++; $display("FAIL read_latency s_cyc got=%b exp=0", s_cyc_o);
        end
        step();
        checks++;
        if ({s_cyc_o, s_stb_o, s_adr_o, grant_o} !== {2'b11, 32'h3000_0010, 2'b01}) begin
            failures++; $display("FAIL read_req got=%h exp=%h", {s_cyc_o, s_stb_o, s_adr_o, grant_o}, {2'b11, 32'h3000_0010, 2'b01});
        end
        step();
        s_ack_i = 1; s_dat_i = 32'hA5A5_1234;
        #1;
        checks++;
        if ({m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o} !== {1'b1, 32'hA5A5_1234, 1'b0, 32'h0}) begin
            failures++; $display("FAIL read_ack got=%h exp=%h", {m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o}, {1'b1, 32'hA5A5_1234, 1'b0, 32'h0});
        end
        step();
        clear_inputs();
        step();
        checks++;
        if (grant_o !== 2'b00) begin
            failures++; $display("FAIL read_release got=%b exp=00", grant_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        s_ack_i = 1;
        #1;
        checks++;
        if ({grant_o, m0_ack_o, m1_ack_o} !== 4'b0110) begin
            failures++; $display("FAIL simul_first got=%b exp=0110", {grant_o, m0_ack_o, m1_ack_o});
        end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        checks++;
        if (grant_o !== 2'b10) begin
            failures++; $display("FAIL simul_handover got=%b exp=10", grant_o);
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++; $display("FAIL simul_rr got=%b exp=01", grant_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_hold();
        int m0_acks = 0;
        int m1_acks = 0;
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0040;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1; s_ack_i = 1; #1;
            m0_acks += int'(m0_ack_o); m1_acks += int'(m1_ack_o);
            step();
            m1_stb_i = 0; s_ack_i = 0;
            step();
            checks++;
            if (grant_o !== 2'b10) begin
                failures++; $display("FAIL hold_grant beat=%0d got=%b exp=10", b, grant_o);
            end
        end
        checks++;
        if ({m0_acks, m1_acks} !== {32'd0, 32'd4}) begin
            failures++; $display("FAIL hold_acks got m0=%0d m1=%0d exp m0=0 m1=4", m0_acks, m1_acks);
        end
        m1_cyc_i = 0;
        step();
        checks++;
        if (grant_o !== 2'b01) begin
            failures++; $display("FAIL hold_next got=%b exp=01", grant_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h0000_0080; m1_dat_i = 32'hDEAD_BEEF;
        step();
`ifdef TJRPU_WB_ARB_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            checks++;
            if ({s_stb_o, m1_err_o, timeout_o} !== 3'b100) begin
                failures++; $display("FAIL to_wait k=%0d got=%b exp=100", k, {s_stb_o, m1_err_o, timeout_o});
            end
            step();
        end
        checks++;
        if ({s_stb_o, m1_err_o, timeout_o, m0_err_o} !== 4'b0110) begin
            failures++; $display("FAIL to_fire got=%b exp=0110", {s_stb_o, m1_err_o, timeout_o, m0_err_o});
        end
        step();
        checks++;
        if ({s_stb_o, m1_err_o, timeout_o, grant_o} !== 5'b10010) begin
            failures++; $display("FAIL to_after got=%b exp=10010", {s_stb_o, m1_err_o, timeout_o, grant_o});
        end
`else
        for (int k = 0; k < 3 * TO; k++) begin
            checks++;
            if ({s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o, grant_o} !== 7'b1000010) begin
                failures++; $display("FAIL stall k=%0d got=%b exp=1000010", k, {s_stb_o, m1_ack_o, m1_err_o, m0_err_o, timeout_o, grant_o});
            end
            step();
        end
`endif
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            m0_cyc_i = m0_cyc_i ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
            m1_cyc_i = m1_cyc_i ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
            m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_ack_i = ($urandom_range(3) == 0);
            s_dat_i = $urandom;
            #1;
            compute_exp();
            checks++;
            if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== exp_s) begin
                failures++; $display("FAIL rand_s n=%0d got=%h exp=%h", n, {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, exp_s);
            end
            checks++;
            if ({m0_ack_o, m0_err_o, m0_dat_o} !== exp_m0) begin
                failures++; $display("FAIL rand_m0 n=%0d got=%h exp=%h", n, {m0_ack_o, m0_err_o, m0_dat_o}, exp_m0);
            end
            checks++;
            if ({m1_ack_o, m1_err_o, m1_dat_o} !== exp_m1) begin
                failures++; $display("FAIL rand_m1 n=%0d got=%h exp=%h", n, {m1_ack_o, m1_err_o, m1_dat_o}, exp_m1);
            end
            checks++;
            if ({timeout_o, grant_o} !== exp_misc) begin
                failures++; $display("FAIL rand_misc n=%0d got=%b exp=%b", n, {timeout_o, grant_o}, exp_misc);
            end
            step();
        end
        clear_inputs();
        step();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        clear_inputs();
        owner = -1; fav = 0; tcnt = 0; terr = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_hold();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
